// File: rtl/muldiv_if.sv
// muldiv_if: execute-stage handshake between the pipeline and muldiv_unit.
interface muldiv_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             read_hilo;
    logic             busy;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;
    modport master (output start, op, rs_data, rt_data, read_hilo,
                    input  busy, stall, hi, lo, div_by_zero);
    modport slave  (input  start, op, rs_data, rt_data, read_hilo,
                    output busy, stall, hi, lo, div_by_zero);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO state and a pipeline stall.
// Signed ops run on magnitudes; signs are reapplied in a single FIXUP cycle.
module muldiv_unit #(parameter int WIDTH = 32) (
    input  logic    clk,
    input  logic    nrst,
    muldiv_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;
    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}; divide: low half is dividend shifting into quotient.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, neg_p_q, neg_p_d, neg_r_q, neg_r_d, dz_q, dz_d;
    logic               sign_rs, sign_rt;
    logic [WIDTH-1:0]   abs_rs, abs_rt, quo, rmd;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   diff;
    logic [2*WIDTH-1:0] prod;

    assign sign_rs = ~bus.op[0] & bus.rs_data[WIDTH-1];
    assign sign_rt = ~bus.op[0] & bus.rt_data[WIDTH-1];
    assign abs_rs  = sign_rs ? -bus.rs_data : bus.rs_data;
    assign abs_rt  = sign_rt ? -bus.rt_data : bus.rt_data;
    assign sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q & {WIDTH{acc_q[0]}}};
    // Extra top bit is the borrow; a zero divisor never borrows, giving all-ones quotient.
    assign diff    = {rem_q, acc_q[WIDTH-1]} - {2'b00, b_q};
    assign prod    = neg_p_q ? -acc_q : acc_q;
    assign quo     = (neg_p_q & ~dz_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rmd     = neg_r_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_p_d  = neg_p_q;
        neg_r_d  = neg_r_q;
        dz_d     = dz_q;
        case (state_q)
            IDLE: if (bus.start) begin
                if (!bus.op[2]) begin
                    acc_d    = {{WIDTH{1'b0}}, abs_rs};
                    rem_d    = '0;
                    b_d      = abs_rt;
                    is_div_d = bus.op[1];
                    neg_p_d  = sign_rs ^ sign_rt;
                    neg_r_d  = sign_rs;
                    dz_d     = bus.op[1] && (bus.rt_data == '0);
                    cnt_d    = CW'(WIDTH - 1);
                    state_d  = CALC;
                end else if (bus.op[1:0] == 2'd0) begin
                    hi_d = bus.rs_data;
                end else if (bus.op[1:0] == 2'd1) begin
                    lo_d = bus.rs_data;
                end
            end
            CALC: begin
                acc_d   = is_div_q ? {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~diff[WIDTH+1]}
                                   : {sum, acc_q[WIDTH-1:1]};
                rem_d   = !is_div_q ? rem_q
                        : diff[WIDTH+1] ? {rem_q[WIDTH-1:0], acc_q[WIDTH-1]} : diff[WIDTH:0];
                cnt_d   = cnt_q - CW'(1);
                state_d = (cnt_q == '0) ? FIXUP : CALC;
            end
            FIXUP: begin
                hi_d    = is_div_q ? rmd : prod[2*WIDTH-1:WIDTH];
                lo_d    = is_div_q ? quo : prod[WIDTH-1:0];
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_p_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_p_q  <= neg_p_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.stall       = bus.busy & (bus.read_hilo | bus.start);
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit; expected HI/LO come from a
// behavioural arithmetic model and are queued as each op is issued.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic nrst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [63:0] exp_q[$];

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .nrst(nrst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        longint q, r;
        logic [63:0] res;
        res = 64'd0;
        if (op == 3'd0) res = sa * sb;
        else if (op == 3'd1) res = ua * ub;
        else if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
        else if (op == 3'd2) begin
            q = sa / sb;
            r = sa % sb;
            res = {r[31:0], q[31:0]};
        end else res = {a % b, a / b};
        return res;
    endfunction

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cyc);
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 0;
        while (bus.busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({bus.busy, bus.stall, bus.div_by_zero, bus.hi, bus.lo} !== 67'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b hi=%h lo=%h dz=%b, want all zero", bus.busy, bus.hi, bus.lo, bus.div_by_zero);
        end
        @(negedge clk);
        nrst = 1'b1;
    endtask

    task automatic test_mult();
        logic [2:0]  ops[5] = '{3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
        logic [31:0] as[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h8000_0000, 32'h1234_5678, 32'h7FFF_FFFF};
        logic [31:0] bs[5]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
        logic [63:0] e;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc !== 33) begin errors++; $display("FAIL mult_latency[%0d] got=%0d want=33", i, cyc); end
            checks++;
            if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL mult_result[%0d] got=%h_%h want=%h", i, bus.hi, bus.lo, e); end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops[5] = '{3'd2, 3'd3, 3'd2, 3'd2, 3'd3};
        logic [31:0] as[5]  = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'h8000_0000, 32'hDEAD_BEEF};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd1000};
        logic [63:0] e;
        int cyc;
        for (int i = 0; i < 5; i++) begin
            run_op(ops[i], as[i], bs[i], cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc !== 33) begin errors++; $display("FAIL div_latency[%0d] got=%0d want=33", i, cyc); end
            checks++;
            if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL div_result[%0d] got=%h_%h want=%h", i, bus.hi, bus.lo, e); end
            checks++;
            if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL div_dz_clear[%0d] got=%b want=0", i, bus.div_by_zero); end
        end
    endtask

    task automatic test_div_by_zero();
        logic [2:0]  ops[2] = '{3'd3, 3'd2};
        logic [31:0] as[2]  = '{32'h0000_1234, 32'hFFFF_FFFB};
        logic [63:0] e;
        int cyc;
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], as[i], 32'd0, cyc);
            e = exp_q.pop_front();
            checks++;
            if (cyc !== 33) begin errors++; $display("FAIL dz_latency[%0d] got=%0d want=33", i, cyc); end
            checks++;
            if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL dz_result[%0d] got=%h_%h want=%h", i, bus.hi, bus.lo, e); end
            checks++;
            if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag[%0d] got=%b want=1", i, bus.div_by_zero); end
        end
        run_op(3'd1, 32'd6, 32'd7, cyc);
        e = exp_q.pop_front();
        checks++;
        if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_cleared_by_multu got=%b want=0", bus.div_by_zero); end
        checks++;
        if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL dz_next_multu got=%h_%h want=%h", bus.hi, bus.lo, e); end
    endtask

    task automatic test_stall();
        logic [63:0] e;
        logic [31:0] old_hi;
        int n;
        old_hi = bus.hi;
        exp_q.push_back(model(3'd3, 32'd1000, 32'd7));
        @(negedge clk);
        bus.read_hilo = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin errors++; $display("FAIL stall_idle got=%b want=0", bus.stall); end
        bus.read_hilo = 1'b0;
        bus.start = 1'b1; bus.op = 3'd3; bus.rs_data = 32'd1000; bus.rt_data = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.stall} !== 2'b10) begin errors++; $display("FAIL stall_no_request got busy=%b stall=%b want busy=1 stall=0", bus.busy, bus.stall); end
        @(negedge clk);
        bus.read_hilo = 1'b1;
        #1;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            checks++;
            if (bus.stall !== 1'b1 || bus.hi !== old_hi) begin
                errors++;
                $display("FAIL stall_busy[%0d] got stall=%b hi=%h want stall=1 hi=%h", n, bus.stall, bus.hi, old_hi);
            end
            @(negedge clk);
            #1;
        end
        e = exp_q.pop_front();
        checks++;
        if (n !== 32) begin errors++; $display("FAIL stall_cycles got=%0d want=32", n); end
        checks++;
        if ({bus.stall, bus.hi, bus.lo} !== {1'b0, e}) begin
            errors++;
            $display("FAIL stall_release got stall=%b hi=%h lo=%h want stall=0 %h", bus.stall, bus.hi, bus.lo, e);
        end
        bus.read_hilo = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] e;
        int n;
        exp_q.push_back(model(3'd0, 32'hFFFF_FFF0, 32'd3));
        exp_q.push_back(model(3'd0, 32'd1234, 32'hFFFF_FF00));
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.rs_data = 32'hFFFF_FFF0; bus.rt_data = 32'd3;
        @(negedge clk);
        bus.rs_data = 32'd1234; bus.rt_data = 32'hFFFF_FF00;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            checks++;
            if (bus.stall !== 1'b1) begin errors++; $display("FAIL b2b_stall[%0d] got=%b want=1", n, bus.stall); end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL b2b_first got=%h_%h want=%h", bus.hi, bus.lo, e); end
        @(negedge clk);
        bus.start = 1'b0;
        n = 0;
        while (bus.busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        e = exp_q.pop_front();
        checks++;
        if (n !== 33) begin errors++; $display("FAIL b2b_second_latency got=%0d want=33", n); end
        checks++;
        if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL b2b_second got=%h_%h want=%h", bus.hi, bus.lo, e); end
    endtask

    task automatic test_move();
        logic [2:0]  ops[3]  = '{3'd4, 3'd5, 3'd6};
        logic [31:0] vals[3] = '{32'h0000_CAFE, 32'h0BAD_F00D, 32'h5555_AAAA};
        logic [31:0] eh, el;
        eh = bus.hi;
        el = bus.lo;
        for (int i = 0; i < 3; i++) begin
            if (ops[i] == 3'd4) eh = vals[i];
            if (ops[i] == 3'd5) el = vals[i];
            @(negedge clk);
            bus.start = 1'b1; bus.op = ops[i]; bus.rs_data = vals[i];
            @(negedge clk);
            bus.start = 1'b0;
            checks++;
            if ({bus.busy, bus.hi, bus.lo} !== {1'b0, eh, el}) begin
                errors++;
                $display("FAIL move[%0d] got busy=%b hi=%h lo=%h want busy=0 hi=%h lo=%h", i, bus.busy, bus.hi, bus.lo, eh, el);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [63:0] e;
        int cyc;
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd2; bus.rs_data = 32'd100; bus.rt_data = 32'd0;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if ({bus.busy, bus.div_by_zero} !== 2'b11) begin errors++; $display("FAIL areset_pre got busy=%b dz=%b want 1 1", bus.busy, bus.div_by_zero); end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.div_by_zero, bus.hi, bus.lo} !== 66'd0) begin
            errors++;
            $display("FAIL areset_immediate got busy=%b dz=%b hi=%h lo=%h want all zero", bus.busy, bus.div_by_zero, bus.hi, bus.lo);
        end
        @(negedge clk);
        nrst = 1'b1;
        run_op(3'd1, 32'd3, 32'd4, cyc);
        e = exp_q.pop_front();
        checks++;
        if (cyc !== 33) begin errors++; $display("FAIL areset_recover_latency got=%0d want=33", cyc); end
        checks++;
        if ({bus.hi, bus.lo} !== e) begin errors++; $display("FAIL areset_recover got=%h_%h want=%h", bus.hi, bus.lo, e); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 3'd0; bus.rs_data = '0; bus.rt_data = '0; bus.read_hilo = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_div_by_zero();
        test_stall();
        test_back_to_back();
        test_move();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO registers, instantiated inside the execute stage. It directly feeds the memory stage, which receives HI/LO results through the execute result path. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, holding HI/LO as architectural state. While an operation is in flight it raises a stall for any dependent MFHI/MFLO or any new mul/div issue.

Parameters:
WIDTH, 32, operand and HI/LO width (matches Constants::WIDTH).

Ports:
clk  input  1  rising-edge clock
nrst  input  1  asynchronous active-low reset
start  input  1  op valid in execute this cycle; held by upstream while stall=1
op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 ignored
rs_data  input  WIDTH  multiplicand / dividend / MTHI-MTLO source
rt_data  input  WIDTH  multiplier / divisor
read_hilo  input  1  MFHI or MFLO in execute this cycle
busy  output  1  operation in flight
stall  output  1  pipeline hold request (combinational)
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
div_by_zero  output  1  last DIV/DIVU had rt_data==0

Behaviour:
- Reset, asynchronous, any time including mid-operation:
  - state=IDLE; busy=0; hi=0; lo=0; div_by_zero=0.
  - Partial results are discarded.
- States: IDLE, CALC, FIXUP. busy = (state != IDLE).
- stall = busy & (read_hilo | start). Combinational, no registered delay.
- IDLE with start=1:
  - op 0–3: latch operands.
    - Signed ops (0, 2) latch absolute values plus sign flags (quotient/product sign = sign_rs ^ sign_rt; remainder sign = sign_rs).
    - Unsigned ops latch raw values.
    - Load iteration counter = WIDTH-1; next state CALC.
    - div_by_zero <= (op is 2/3) & (rt_data==0). It is cleared on the start of every op 0–3.
  - op 4: hi <= rs_data at the edge; state stays IDLE; busy stays 0.
  - op 5: lo <= rs_data likewise.
  - op 6/7: no effect.
- CALC: one iteration per cycle for WIDTH cycles; counter decrements; at counter==0 go to FIXUP.
  - Multiply: radix-2 shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract. Remainder register is WIDTH+1 bits to hold the borrow.
- FIXUP, one cycle:
  - Apply two's-complement negation per the sign flags, modulo 2^WIDTH.
  - At the edge write hi (product upper / remainder) and lo (product lower / quotient); state -> IDLE.
- Latency: start accepted at edge E0; busy=1 for WIDTH+1 cycles; hi/lo hold new values after edge E0+WIDTH+1, at which point busy=0.
- hi/lo are unchanged during CALC/FIXUP; reads during busy are prevented by stall.
- Start while busy: ignored (no restart, no latch). stall=1 keeps the upstream instruction in place so it is accepted in the first IDLE cycle.
- Divide by zero:
  - The algorithm runs the full latency.
  - Result is defined for both DIV and DIVU: lo = all ones, hi = rs_data (raw, sign fixup suppressed).
  - No exception is raised.
- Signed overflow (DIV 0x80000000 / -1): lo = 0x80000000, hi = 0, by natural wrap of the negation.
- Same-cycle read_hilo in IDLE returns current hi/lo; the write from a finishing FIXUP is visible the cycle after.

Test Plan:
1. MULTU 0xFFFFFFFF × 0xFFFFFFFF -> busy high exactly 33 cycles; then hi=0xFFFFFFFE, lo=0x00000001.
2. MULT -3 (0xFFFFFFFD) × 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULT 0x80000000 × 0x80000000 -> hi=0x40000000, lo=0.
3. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7 / 2 -> lo=3, hi=1. DIV 7 / -2 -> lo=0xFFFFFFFD, hi=1.
4. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1; next MULTU clears div_by_zero.
5. Stall and move ops:
   - read_hilo=1 from cycle 2 of a DIVU -> stall=1 until busy falls, then 0 with the new lo visible.
   - Second MULT held with start=1 during busy -> accepted on the first idle cycle; result matches the second op only.
   - MTHI 0xCAFE in IDLE -> hi=0xCAFE next cycle, busy never asserts.
6. Reset and recovery:
   - nrst low at cycle 10 of a DIV -> busy, hi, lo, div_by_zero = 0 immediately (before the next edge).
   - After release, MULTU 3 × 4 -> lo=12, hi=0 after 33 cycles.
